// File: rtl/cmd_encoder_pkg.sv
// rtl/cmd_encoder_pkg.sv - shared types and constants for the command encoder
package cmd_encoder_pkg;

    localparam int CMD_ADDR_W   = 12;
    localparam int CMD_NIBBLE_W = 4;
    localparam int CMD_WORD_W   = 16;
    localparam int MAX_NIBBLES  = 4;
    localparam int CMD_CNT_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } cmd_state_e;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0]  address;
        logic [CMD_WORD_W-1:0]  data;
        logic [CMD_CNT_W-1:0]   nibbles;
    } cmd_req_t;

    // Requests asking for more nibbles than the data field holds send all four.
    function automatic logic [CMD_CNT_W-1:0] clamp_nibbles(input logic [CMD_CNT_W-1:0] n);
        return (n > CMD_CNT_W'(MAX_NIBBLES)) ? CMD_CNT_W'(MAX_NIBBLES) : n;
    endfunction

endpackage

// File: rtl/cmd_req_fifo.sv
// rtl/cmd_req_fifo.sv - synchronous FIFO of request records
// DEPTH must be a power of two; pointers carry one extra wrap bit.
module cmd_req_fifo
    import cmd_encoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  cmd_req_t push_data_i,
    input  logic     pop_i,
    output cmd_req_t pop_data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmd_req_t      mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/command_encoder.sv
// rtl/command_encoder.sv - splits requests into nibble command strobes on the DIF bus
// CMD_ENCODER_FIFO_EN selects a request FIFO instead of the single holding register.
module command_encoder
    import cmd_encoder_pkg::*;
#(
    parameter int GAP_CYCLES = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   Clk,
    input  logic                   reset_n,
    input  logic                   ReqValid,
    output logic                   ReqReady,
    input  logic [CMD_ADDR_W-1:0]  ReqAddress,
    input  logic [CMD_WORD_W-1:0]  ReqData,
    input  logic [CMD_CNT_W-1:0]   ReqNibbles,
    output logic                   CommandEn,
    output logic [CMD_WORD_W-1:0]  CommandWord,
    output logic                   Busy
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two of at least 2");
    end

    cmd_state_e               state_q;
    logic [CMD_ADDR_W-1:0]    addr_q;
    logic [CMD_WORD_W-1:0]    data_q;
    logic [CMD_CNT_W-1:0]     remaining_q;
    logic [GW-1:0]            gap_cnt_q;
    logic                     cmd_en_q;
    logic [CMD_WORD_W-1:0]    cmd_word_q;

    cmd_req_t                 req_in;
    cmd_req_t                 req_head;
    logic                     req_avail;
    logic                     req_take;
    logic [CMD_CNT_W-1:0]     req_len;

    assign req_in = {ReqAddress, ReqData, ReqNibbles};

`ifdef CMD_ENCODER_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    cmd_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk_i       (Clk),
        .rst_ni      (reset_n),
        .push_i      (ReqValid),
        .push_data_i (req_in),
        .pop_i       (req_take),
        .pop_data_o  (req_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign ReqReady  = !fifo_full;
    assign req_avail = !fifo_empty;
    assign Busy      = (state_q != IDLE) || !fifo_empty;
`else
    // The working registers double as the holding register: accept only when idle.
    assign req_head  = req_in;
    assign ReqReady  = (state_q == IDLE);
    assign req_avail = ReqValid;
    assign Busy      = (state_q != IDLE);
`endif

    assign req_take = (state_q == IDLE) && req_avail;
    assign req_len  = clamp_nibbles(req_head.nibbles);

    assign CommandEn   = cmd_en_q;
    assign CommandWord = cmd_word_q;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            remaining_q <= '0;
            gap_cnt_q   <= '0;
            cmd_en_q    <= 1'b0;
            cmd_word_q  <= '0;
        end else begin
            cmd_en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Zero-length requests are consumed here without leaving IDLE.
                    if (req_take && (req_len != '0)) begin
                        addr_q      <= req_head.address;
                        data_q      <= req_head.data;
                        remaining_q <= req_len;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    cmd_en_q    <= 1'b1;
                    cmd_word_q  <= {addr_q, data_q[CMD_NIBBLE_W-1:0]};
                    addr_q      <= addr_q + 1'b1;
                    data_q      <= data_q >> CMD_NIBBLE_W;
                    remaining_q <= remaining_q - 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_q   <= GAP;
                        gap_cnt_q <= GAP_LOAD;
                    end else if (remaining_q == CMD_CNT_W'(1)) begin
                        state_q <= IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= (remaining_q != '0) ? SEND : IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/command_encoder.md
# command_encoder

Generates the single-cycle CommandEn / CommandWord strobes consumed by the per-register command decoders on the DIF. Accepts a request of target address, value and width, splits the value into 4-bit nibbles, and emits one 16-bit command word per nibble on consecutive addresses. Sits between the host/USB command path or an internal sequencer and the shared command bus.

## Interface
- GAP_CYCLES, 1: idle cycles forced between consecutive CommandEn pulses (0 = back-to-back).
- FIFO_DEPTH, 4: request FIFO depth, power of two; used only when the FIFO is compiled in.
- Clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ReqValid  input  1  request present.
- ReqReady  output  1  request accepted when ReqValid && ReqReady on a rising edge.
- ReqAddress  input  12  address of nibble 0.
- ReqData  input  16  value; nibble i is ReqData[4i+3:4i].
- ReqNibbles  input  3  number of nibbles to send, 1..4.
- CommandEn  output  1  one-cycle strobe qualifying CommandWord.
- CommandWord  output  16  {address[11:0], nibble[3:0]}.
- Busy  output  1  high while any request is held or being sent.

## Operation
- Word i of a request = {ReqAddress + i (mod 4096), ReqData[4i+3:4i]}, i = 0..ReqNibbles-1, LSB nibble first.
- ReqNibbles = 0: request accepted and discarded, no word emitted. ReqNibbles > 4: clamped to 4.
- Address arithmetic 12-bit, wraps FFF -> 000; no error flag.
- FSM: IDLE -> SEND on available request; SEND drives one word, decrements remaining count; remaining > 0 -> GAP (or SEND if GAP_CYCLES = 0); remaining = 0 -> GAP then IDLE, or IDLE if GAP_CYCLES = 0; GAP counts GAP_CYCLES then -> SEND or IDLE/next request.
- GAP also applies between the last word of one request and the first word of the next.
- CommandWord holds its last value between strobes; only CommandEn qualifies it.
- Request fields are latched at acceptance; input changes afterwards have no effect.

## Timing
- Reset values: CommandEn 0, CommandWord 16'h0000, Busy 0, ReqReady 1, FSM IDLE, FIFO empty.
- Latency: request accepted at edge t, idle encoder -> CommandEn high during cycle t+1 (FIFO off) or t+2 (FIFO on).
- CommandEn never high for two consecutive cycles when GAP_CYCLES ≥ 1.
- Word spacing: GAP_CYCLES+1 cycles between CommandEn rising edges.
- Reset asserted mid-request: all outputs return to reset values immediately; partial request and FIFO contents discarded, no further words.
- Busy deasserts in the cycle after the final GAP completes with nothing pending.

## Configuration
- CMD_ENCODER_FIFO_EN defined: request FIFO of FIFO_DEPTH entries; ReqReady = !full; accept while sending; simultaneous push and pop on a full FIFO is not allowed (ReqReady low when full).
- Not defined: single holding register; ReqReady high only in IDLE with nothing held; one request in flight.

## Structure
- Package cmd_encoder_pkg: state enum (IDLE, SEND, GAP), CMD_ADDR_W = 12, CMD_NIBBLE_W = 4, CMD_WORD_W = 16, MAX_NIBBLES = 4, request record type {address, data, nibbles}.
- Sub-module cmd_req_fifo: synchronous FIFO of request records, instantiated only under CMD_ENCODER_FIFO_EN.

## Test plan
- Request addr 12'h0A0, data 16'h0003, nibbles 1 -> single strobe CommandWord 16'h0A03, Busy low afterwards.
- Addr 12'h100, data 16'hBEEF, nibbles 4, GAP_CYCLES 1 -> words 16'h100F, 16'h101E, 16'h102E, 16'h103B, strobes 2 cycles apart.
- Addr 12'hFFE, data 16'h0021, nibbles 3 -> 16'hFFE1, 16'hFFF2, 16'h0000 (wrap).
- Nibbles 0 then nibbles 7 with data 16'h4321, addr 12'h010 -> nothing for first; second emits four words 16'h0101..16'h0134.
- FIFO on: five back-to-back requests, depth 4 -> ReqReady drops while full, all accepted requests emitted in order, none lost.
- reset_n low after second word of a 4-nibble request -> CommandEn 0 same cycle, no remaining words after release, ReqReady 1.
